// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control unit: FSM states, opcodes,
// ALU/immediate select codes, status flag indices and the branch-condition helper.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_ILLEGAL
  } iclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // alu_op is {funct7[5], funct3}
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Flags come from rs1 - rs2; unsupported funct3 values never branch.
  function automatic logic branch_taken(input logic [2:0] f3, input logic [3:0] flags);
    case (f3)
      F3_BEQ:  return flags[FLAG_Z];
      F3_BNE:  return !flags[FLAG_Z];
      F3_BLT:  return flags[FLAG_N] ^ flags[FLAG_V];
      F3_BGE:  return !(flags[FLAG_N] ^ flags[FLAG_V]);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cu_if.sv
// Memory handshake between the control unit (master) and the shared single-ported memory.
interface multicycle_cu_if;
  // mem_req is held high with a stable mrw until the cycle in which mem_ready is high;
  // that cycle completes the transfer. mem_ready outside a request is ignored.
  logic mem_req;
  logic mrw;
  logic mem_ready;

  modport master (output mem_req, output mrw, input mem_ready);
  modport slave  (input mem_req, input mrw, output mem_ready);
endinterface

// File: rtl/cu_decode.sv
// Combinational instruction classifier: maps the IR to class, ALU op, immediate format
// and branch funct3.
module cu_decode
  import cu_pkg::*;
(
  input  logic [31:0] inst,
  output iclass_t     iclass,
  output logic [3:0]  alu_op,
  output logic [1:0]  imm_sel,
  output logic [2:0]  br_funct
);

  logic [2:0] f3;
  logic       f7_5;
  logic       unused_inst;

  assign f3          = inst[14:12];
  assign f7_5        = inst[30];
  assign br_funct    = f3;
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    iclass  = CL_ILLEGAL;
    alu_op  = ALU_ADD;
    imm_sel = IMM_NONE;
    case (inst[6:0])
      OP_R: begin
        iclass = CL_R;
        alu_op = {f7_5, f3};
      end
      OP_I: begin
        // Only the shift-right pair uses funct7[5]; elsewhere that bit is immediate data.
        iclass  = CL_I;
        imm_sel = IMM_I;
        alu_op  = {(f3 == 3'b101) ? f7_5 : 1'b0, f3};
      end
      OP_LOAD: begin
        iclass  = CL_LOAD;
        imm_sel = IMM_I;
      end
      OP_STORE: begin
        iclass  = CL_STORE;
        imm_sel = IMM_S;
      end
      OP_BRANCH: begin
        iclass  = CL_BRANCH;
        imm_sel = IMM_B;
        alu_op  = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control FSM for the RV32I-subset datapath with a shared req/ready memory.
// Define ILLEGAL_TRAP_EN to park in TRAP on an illegal opcode instead of treating it as a NOP.
module multicycle_cu
  import cu_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic [3:0]           status,
  multicycle_cu_if.master      mem,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pcsrc,
  output logic                 alusrc,
  output logic                 rw,
  output logic                 wb,
  output logic [1:0]           imm_sel,
  output logic [3:0]           alu_op,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state_o,
  output logic                 illegal
);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t               state;
  logic [INSTRET_W-1:0] instret_q;
  iclass_t              iclass;
  logic [3:0]           dec_alu_op;
  logic [1:0]           dec_imm_sel;
  logic [2:0]           br_funct;
  logic                 retire;
  logic                 mem_req_c;
  logic                 mrw_c;
  logic                 unused_flags;

  assign unused_flags = status[FLAG_C];

  cu_decode u_decode (
    .inst     (inst),
    .iclass   (iclass),
    .alu_op   (dec_alu_op),
    .imm_sel  (dec_imm_sel),
    .br_funct (br_funct)
  );

  // Final cycle of every instruction; an illegal opcode counts only when it is a NOP.
  always_comb begin
    retire = 1'b0;
    case (state)
      ST_DECODE: retire = !TRAP_EN && (iclass == CL_ILLEGAL);
      ST_MEM:    retire = mem.mem_ready && (iclass == CL_STORE);
      ST_WB:     retire = 1'b1;
      ST_BRANCH: retire = 1'b1;
      default:   retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      instret_q <= '0;
    end else begin
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
      case (state)
        ST_FETCH:  if (mem.mem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          case (iclass)
            CL_R, CL_I, CL_LOAD, CL_STORE: state <= ST_EXEC;
            CL_BRANCH:                     state <= ST_BRANCH;
            default:                       state <= TRAP_EN ? ST_TRAP : ST_FETCH;
          endcase
        end
        ST_EXEC:   state <= (iclass == CL_LOAD || iclass == CL_STORE) ? ST_MEM : ST_WB;
        ST_MEM: begin
          if (mem.mem_ready) state <= (iclass == CL_LOAD) ? ST_WB : ST_FETCH;
        end
        ST_WB:     state <= ST_FETCH;
        ST_BRANCH: state <= ST_FETCH;
        ST_TRAP:   state <= TRAP_EN ? ST_TRAP : ST_FETCH;
        default:   state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req_c = 1'b0;
    mrw_c     = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pcsrc     = 1'b0;
    alusrc    = 1'b0;
    rw        = 1'b0;
    wb        = 1'b0;
    imm_sel   = IMM_NONE;
    alu_op    = ALU_ADD;
    illegal   = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        ir_we     = mem.mem_ready;
        pc_we     = mem.mem_ready;
      end
      ST_EXEC, ST_MEM, ST_WB: begin
        // ALU controls stay up through MEM/WB so the address and result remain valid.
        alusrc  = (iclass != CL_R);
        imm_sel = dec_imm_sel;
        alu_op  = dec_alu_op;
        if (state == ST_MEM) begin
          mem_req_c = 1'b1;
          mrw_c     = (iclass == CL_STORE);
        end
        if (state == ST_WB) begin
          rw = 1'b1;
          wb = (iclass == CL_LOAD);
        end
      end
      ST_BRANCH: begin
        imm_sel = dec_imm_sel;
        alu_op  = dec_alu_op;
        pcsrc   = 1'b1;
        pc_we   = branch_taken(br_funct, status);
      end
      default: ;
    endcase
`ifdef ILLEGAL_TRAP_EN
    illegal = (state == ST_TRAP);
`endif
    if (rst) begin
      mem_req_c = 1'b0;
      mrw_c     = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pcsrc     = 1'b0;
      alusrc    = 1'b0;
      rw        = 1'b0;
      wb        = 1'b0;
      imm_sel   = 2'b00;
      alu_op    = 4'b0000;
      illegal   = 1'b0;
    end
  end

  assign mem.mem_req = mem_req_c;
  assign mem.mrw     = mrw_c;
  assign instret     = rst ? '0 : instret_q;
  assign state_o     = rst ? 3'd0 : state;

endmodule
